// File: rtl/spi_mem_pkg.sv
// Shared opcodes and FSM state type for the SPI slave memory.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRd,
    StWr,
    StStat,
    StIgn
  } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the SPI pins into clk and turns spi_sclk transitions into
// one-clk sample/shift pulses according to CPOL/CPHA.
module spi_edge_sync #(
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sample_pulse,
  output logic shift_pulse
);

  localparam logic IdleClk = CPOL[0];

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;
  logic                   sclk_lead;
  logic                   sclk_trail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= {SYNC_STAGES{IdleClk}};
      mosi_sync_q <= '0;
      sclk_prev_q <= IdleClk;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
  // MOSI goes through the same depth as SCLK, so it is aligned with the pulse.
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_lead  = (sclk_s != sclk_prev_q) && (sclk_s != IdleClk);
  assign sclk_trail = (sclk_s != sclk_prev_q) && (sclk_s == IdleClk);

  // Gating by cs_n_s also makes a deselect win over a coincident sample edge.
  assign sample_pulse = !cs_n_s && ((CPHA == 0) ? sclk_lead : sclk_trail);
  assign shift_pulse  = !cs_n_s && ((CPHA == 0) ? sclk_trail : sclk_lead);

endmodule

// File: rtl/spi_slave_mem.sv
// SPI slave exposing a byte-addressed memory with READ/WRITE/RDSR/WREN/WRDI
// commands; all logic runs in the clk domain behind spi_edge_sync.
module spi_slave_mem
  import spi_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned ADDR_BYTES  = 3,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic cmd_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          cs_n_s;
  logic          mosi_s;
  logic          sample_pulse;
  logic          shift_pulse;

  state_e        state_q;
  logic [2:0]    bit_q;
  logic [1:0]    abyte_q;
  logic [7:0]    rx_q;
  logic [7:0]    tx_q;
  logic [AW-1:0] addr_q;
  logic          wel_q;
  logic          wr_en_q;
  logic          op_rd_q;
  logic          load_pend_q;
  logic          cs_prev_q;
  logic [1:0]    settle_q;
  logic          armed_q;

  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          cs_fall;
  logic          cs_rise;
  logic          mem_we;
  logic          drive_out;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    mem_rdata_q;

  spi_edge_sync #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_cs       (spi_cs),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .cs_n_s       (cs_n_s),
    .mosi_s       (mosi_s),
    .sample_pulse (sample_pulse),
    .shift_pulse  (shift_pulse)
  );

  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign byte_done = sample_pulse && (bit_q == 3'd7);
  assign cs_fall   = cs_prev_q && !cs_n_s;
  assign cs_rise   = !cs_prev_q && cs_n_s;
  assign mem_we    = (state_q == StWr) && byte_done && wr_en_q;
  assign drive_out = !cs_n_s && ((state_q == StRd) || (state_q == StStat));

  // Single-port synchronous RAM, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= rx_byte;
    end
    mem_rdata_q <= mem[addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_q       <= 3'd0;
      abyte_q     <= 2'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= '0;
      wel_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      op_rd_q     <= 1'b0;
      load_pend_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cs_prev_q   <= cs_n_s;
      busy        <= !cs_n_s;
      cmd_err     <= 1'b0;
      spi_miso_oe <= drive_out;
      spi_miso    <= drive_out && tx_q[7];

      // After reset, only a falling edge that follows a seen-high CS starts a
      // transaction, so a select held low across reset stays ignored.
      if (settle_q != 2'(SYNC_STAGES)) begin
        settle_q <= settle_q + 2'd1;
      end else if (cs_n_s) begin
        armed_q <= 1'b1;
      end

      if (cs_n_s) begin
        if (cs_rise && (state_q == StWr)) begin
          wel_q <= 1'b0;
        end
        state_q     <= StIdle;
        load_pend_q <= 1'b0;
      end else begin
        if (sample_pulse) begin
          bit_q <= bit_q + 3'd1;
          rx_q  <= rx_byte;
        end

        case (state_q)
          StIdle: begin
            if (cs_fall && armed_q) begin
              state_q <= StCmd;
              bit_q   <= 3'd0;
            end
          end

          StCmd: begin
            if (byte_done) begin
              abyte_q <= 2'd0;
              addr_q  <= '0;
              tx_q    <= 8'h00;
              case (rx_byte)
                OP_READ: begin
                  op_rd_q <= 1'b1;
                  state_q <= StAddr;
                end
                OP_WRITE: begin
                  op_rd_q <= 1'b0;
                  wr_en_q <= wel_q;
                  state_q <= StAddr;
                end
                OP_RDSR: begin
                  load_pend_q <= 1'b1;
                  state_q     <= StStat;
                end
                OP_WREN: begin
                  wel_q   <= 1'b1;
                  state_q <= StIgn;
                end
                OP_WRDI: begin
                  wel_q   <= 1'b0;
                  state_q <= StIgn;
                end
                default: begin
                  cmd_err <= 1'b1;
                  state_q <= StIgn;
                end
              endcase
            end
          end

          StAddr: begin
            if (sample_pulse) begin
              // Bits above AW fall off the top of the shift register.
              addr_q <= {addr_q[AW-2:0], mosi_s};
              if (bit_q == 3'd7) begin
                abyte_q <= abyte_q + 2'd1;
                if (abyte_q == 2'(ADDR_BYTES - 1)) begin
                  if (op_rd_q) begin
                    load_pend_q <= 1'b1;
                    state_q     <= StRd;
                  end else begin
                    state_q <= StWr;
                  end
                end
              end
            end
          end

          StRd, StStat: begin
            // mem_rdata_q follows addr_q one clk later; the next shift edge is
            // several clks away, so the pending byte is ready when loaded.
            if (shift_pulse) begin
              if (load_pend_q) begin
                load_pend_q <= 1'b0;
                if (state_q == StRd) begin
                  tx_q   <= mem_rdata_q;
                  addr_q <= addr_q + 1'b1;
                end else begin
                  tx_q <= {6'b0, wel_q, 1'b0};
                end
              end else begin
                tx_q <= {tx_q[6:0], 1'b0};
              end
            end
            if (byte_done) begin
              load_pend_q <= 1'b1;
            end
          end

          StWr: begin
            if (mem_we) begin
              addr_q <= addr_q + 1'b1;
            end
          end

          StIgn: begin
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed bench: one DUT per SPI mode, driven by a bit-banged master model.
module tb_spi_slave_mem;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cs;
  logic [3:0] sclk;
  logic [3:0] mosi;
  wire  [3:0] miso;
  wire  [3:0] oe;
  wire  [3:0] busy;
  wire  [3:0] err;

  int total = 0;
  int bad = 0;
  int err_cyc [4];
  int e0;

  logic [7:0] txb    [16];
  logic [7:0] rxb    [16];
  logic       oe_any [16];
  logic       oe_all [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_mem #(
      .DEPTH       (4096),
      .ADDR_BYTES  (3),
      .CPOL        (g / 2),
      .CPHA        (g % 2),
      .SYNC_STAGES (2)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_cs      (cs[g]),
      .spi_sclk    (sclk[g]),
      .spi_mosi    (mosi[g]),
      .spi_miso    (miso[g]),
      .spi_miso_oe (oe[g]),
      .busy        (busy[g]),
      .cmd_err     (err[g])
    );
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (err[i]) err_cyc[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [63:0] bytes, input int n);
    for (int k = 0; k < n; k++) txb[k] = bytes[8*(n-1-k) +: 8];
  endtask

  task automatic note_oe(input int m, input int k);
    oe_any[k] = oe_any[k] | oe[m];
    oe_all[k] = oe_all[k] & oe[m];
  endtask

  task automatic xfer(input int m, input int k, input int nbits);
    logic pol;
    logic pha;
    pol = (m / 2) != 0;
    pha = (m % 2) != 0;
    oe_any[k] = 1'b0;
    oe_all[k] = 1'b1;
    rxb[k] = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!pha) begin
        mosi[m] = txb[k][i];
        repeat (HALF) @(negedge clk);
        sclk[m] = ~pol;
        rxb[k][i] = miso[m];
        note_oe(m, k);
        repeat (HALF) @(negedge clk);
        sclk[m] = pol;
      end else begin
        sclk[m] = ~pol;
        mosi[m] = txb[k][i];
        repeat (HALF) @(negedge clk);
        sclk[m] = pol;
        rxb[k][i] = miso[m];
        note_oe(m, k);
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic sel(input int m);
    cs[m] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic desel(input int m);
    repeat (HALF) @(negedge clk);
    cs[m] = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic txn(input int m, input int n);
    sel(m);
    for (int k = 0; k < n; k++) xfer(m, k, 8);
    desel(m);
  endtask

  initial begin
    cs    = 4'b1111;
    mosi  = 4'b0000;
    sclk  = 4'b1100;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", {16'h0, miso, oe, busy, err}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      put(64'h06, 1);              txn(m, 1);
      put(64'h02000FFEA55AC3, 7);  txn(m, 7);
      put(64'h0500, 2);            txn(m, 2);
      check($sformatf("m%0d_rdsr_after_write", m), rxb[1], 8'h00);
      put(64'h03000FFE000000, 7);  txn(m, 7);
      check($sformatf("m%0d_rd_ffe", m), rxb[4], 8'hA5);
      check($sformatf("m%0d_rd_fff", m), rxb[5], 8'h5A);
      check($sformatf("m%0d_rd_wrap_000", m), rxb[6], 8'hC3);
      check($sformatf("m%0d_oe_cmd_addr", m),
            {oe_any[0], oe_any[1], oe_any[2], oe_any[3]}, 4'b0000);
      check($sformatf("m%0d_oe_data", m), {oe_all[4], oe_all[5], oe_all[6]}, 3'b111);
      check($sformatf("m%0d_oe_idle", m), oe[m], 1'b0);
    end

    // Write without WEL is discarded
    put(64'h06, 1);              txn(0, 1);
    put(64'h0200001077, 5);      txn(0, 5);
    put(64'h0200001011, 5);      txn(0, 5);
    put(64'h0300001000, 5);      txn(0, 5);
    check("nowel_write_blocked", rxb[4], 8'h77);
    put(64'h06, 1);              txn(0, 1);
    put(64'h0500, 2);            txn(0, 2);
    check("rdsr_wel_set", rxb[1], 8'h02);
    put(64'h0500000000, 5);      txn(0, 5);
    check("rdsr_repeat", {rxb[1], rxb[2], rxb[3], rxb[4]}, 32'h02020202);
    put(64'h04, 1);              txn(0, 1);
    put(64'h0500, 2);            txn(0, 2);
    check("rdsr_wrdi", rxb[1], 8'h00);

    // Unsupported opcode
    e0 = err_cyc[0];
    put(64'h9F00, 2);            txn(0, 2);
    check("bad_op_err_cycles", err_cyc[0] - e0, 1);
    check("bad_op_oe", {oe_any[0], oe_any[1]}, 2'b00);
    check("bad_op_busy_after", busy[0], 1'b0);
    put(64'h0500, 2);            txn(0, 2);
    check("rdsr_after_bad_op", rxb[1], 8'h00);

    // Deselect after 4 bits of the second data byte
    put(64'h06, 1);              txn(0, 1);
    put(64'h020001013C, 5);      txn(0, 5);
    put(64'h06, 1);              txn(0, 1);
    put(64'h02000100B6FF, 6);
    sel(0);
    for (int k = 0; k < 5; k++) xfer(0, k, 8);
    xfer(0, 5, 4);
    desel(0);
    put(64'h030001000000, 6);    txn(0, 6);
    check("partial_first_byte", rxb[4], 8'hB6);
    check("partial_second_untouched", rxb[5], 8'h3C);
    put(64'h0500, 2);            txn(0, 2);
    check("partial_wel_cleared", rxb[1], 8'h00);

    // Reset mid-read, then a stray command under the still-low select
    put(64'h03000FFE00, 5);
    sel(0);
    for (int k = 0; k < 4; k++) xfer(0, k, 8);
    xfer(0, 4, 4);
    check("mid_read_oe_high", oe[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {miso[0], oe[0], busy[0], err[0]}, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    put(64'h06, 1);
    xfer(0, 0, 8);
    desel(0);
    put(64'h0500, 2);            txn(0, 2);
    check("post_rst_wel", rxb[1], 8'h00);
    put(64'h03000FFE000000, 7);  txn(0, 7);
    check("post_rst_read", {8'h00, rxb[4], rxb[5], rxb[6]}, 32'h00A55AC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
